// File: rtl/tetris_pkg.sv
// Shared tetromino types and constants for picker, spawn and draw logic.
package tetris_pkg;

  typedef enum logic [2:0] {
    PIECE_I = 3'd0,
    PIECE_O = 3'd1,
    PIECE_T = 3'd2,
    PIECE_S = 3'd3,
    PIECE_Z = 3'd4,
    PIECE_J = 3'd5,
    PIECE_L = 3'd6
  } piece_t;

  localparam logic [2:0] PIECE_NONE = 3'd7;
  localparam int         NUM_PIECES = 7;

  // Folds two slices of the random word so low-bit LFSR correlation is diluted.
  function automatic logic [2:0] cand_of(input logic [15:0] rnd);
    return rnd[2:0] ^ rnd[13:11];
  endfunction

endpackage

// File: rtl/piece_fifo.sv
// Circular buffer of piece codes with head and second-entry read ports.
module piece_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic [W-1:0] second,
  output logic [3:0]   count
);

  localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
  localparam logic [3:0]    DEPTH_C = 4'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [3:0]    count_q, count_d;
  logic          do_push_s, do_pop_s;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    if (p == LAST) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Pointer and occupancy next-state.
  always_comb begin
    do_push_s = push && (count_q != DEPTH_C);
    do_pop_s  = pop && (count_q != 4'd0);
    head_d    = do_pop_s  ? wrap_inc(head_q) : head_q;
    tail_d    = do_push_s ? wrap_inc(tail_q) : tail_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 4'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; stale entries are masked by count downstream.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[tail_q] <= wdata;
    end
  end

  assign head   = mem_q[head_q];
  assign second = mem_q[wrap_inc(head_q)];
  assign count  = count_q;

endmodule

// File: rtl/piece_picker.sv
// Turns LFSR words into tetromino types and buffers them for the game FSM.
// Define PIECE_BAG7_EN for 7-bag mode (no repeats within each aligned group of 7).
module piece_picker
  import tetris_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] rand_num,
  input  logic        req,
  output logic        piece_valid,
  output logic [2:0]  piece,
  output logic [2:0]  preview,
  output logic [3:0]  count,
  output logic [7:0]  reject_cnt
);

  logic [2:0] cand_s, head_s, second_s;
  logic [3:0] count_s;
  logic       full_s, blocked_s, reject_s, push_s, pop_s;
  logic [7:0] rej_q, rej_d;

`ifdef PIECE_BAG7_EN
  localparam logic [NUM_PIECES-1:0] ALL_USED = '1;
  logic [NUM_PIECES-1:0] used_q, used_d, used_set_s;
  logic [7:0]            used_ext_s;
`endif

  // Candidate filtering and push/pop decisions.
  always_comb begin
    cand_s = cand_of(rand_num);
    full_s = (count_s == 4'(QUEUE_DEPTH));
`ifdef PIECE_BAG7_EN
    // Bit 7 stands in for PIECE_NONE so one lookup covers both reject reasons.
    used_ext_s = {1'b1, used_q};
    blocked_s  = used_ext_s[cand_s];
`else
    blocked_s  = (cand_s == PIECE_NONE);
`endif
    reject_s = !full_s && blocked_s;
    push_s   = !full_s && !blocked_s;
    pop_s    = req && (count_s != 4'd0);
    if (reject_s && (rej_q != 8'hFF)) begin
      rej_d = rej_q + 8'd1;
    end else begin
      rej_d = rej_q;
    end
`ifdef PIECE_BAG7_EN
    used_set_s = used_q | (NUM_PIECES'(1) << cand_s);
    if (push_s) begin
      used_d = (used_set_s == ALL_USED) ? '0 : used_set_s;
    end else begin
      used_d = used_q;
    end
`endif
  end

  // Reject counter and bag mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      rej_q  <= 8'd0;
`ifdef PIECE_BAG7_EN
      used_q <= '0;
`endif
    end else begin
      rej_q  <= rej_d;
`ifdef PIECE_BAG7_EN
      used_q <= used_d;
`endif
    end
  end

  piece_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .W     (3)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push_s),
    .pop    (pop_s),
    .wdata  (cand_s),
    .head   (head_s),
    .second (second_s),
    .count  (count_s)
  );

  // Output decode from registered queue state.
  always_comb begin
    piece_valid = (count_s != 4'd0);
    if (count_s != 4'd0) begin
      piece = head_s;
    end else begin
      piece = 3'd0;
    end
    if (count_s >= 4'd2) begin
      preview = second_s;
    end else begin
      preview = PIECE_NONE;
    end
  end

  assign count      = count_s;
  assign reject_cnt = rej_q;

endmodule

// File: tb/tb_piece_picker.sv
// Scoreboard bench for piece_picker: a queue-based reference model predicts
// the post-edge state per cycle; a monitor pops and compares after each edge.
module tb_piece_picker;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] rand_num = 16'h0000;
  logic        req = 1'b0;
  logic        piece_valid;
  logic [2:0]  piece, preview;
  logic [3:0]  count;
  logic [7:0]  reject_cnt;

  piece_picker #(.QUEUE_DEPTH(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .rand_num    (rand_num),
    .req         (req),
    .piece_valid (piece_valid),
    .piece       (piece),
    .preview     (preview),
    .count       (count),
    .reject_cnt  (reject_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cnt;
    logic       v;
    logic [2:0] p;
    logic [2:0] pv;
    logic [7:0] rj;
  } exp_t;

  exp_t       exp_q [$];
  logic [2:0] mq [$];
  int         m_rej = 0;
  bit [6:0]   m_used = '0;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: apply one cycle of the specification's rules to the model queue.
  task automatic step(input logic r, input logic [15:0] rn, input logic rq);
    logic [2:0] c;
    bit         full, blocked;
    exp_t       e;
    @(negedge clk);
    rst = r;
    rand_num = rn;
    req = rq;
    c = rn[2:0] ^ rn[13:11];
    if (r) begin
      mq.delete();
      m_rej = 0;
      m_used = '0;
    end else begin
      full = (mq.size() == D);
      blocked = (c == 3'd7);
`ifdef PIECE_BAG7_EN
      if (!blocked && m_used[c]) blocked = 1'b1;
`endif
      if (rq && mq.size() > 0) void'(mq.pop_front());
      if (!full) begin
        if (blocked) begin
          if (m_rej < 255) m_rej++;
        end else begin
          mq.push_back(c);
`ifdef PIECE_BAG7_EN
          m_used[c] = 1'b1;
          if (m_used == 7'h7F) m_used = '0;
`endif
        end
      end
    end
    e.cnt = 4'(mq.size());
    e.v   = (mq.size() != 0);
    e.p   = (mq.size() > 0) ? mq[0] : 3'd0;
    e.pv  = (mq.size() > 1) ? mq[1] : 3'd7;
    e.rj  = 8'(m_rej);
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the oldest prediction after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("count",       8'(count),       8'(e.cnt));
      chk("piece_valid", 8'(piece_valid), 8'(e.v));
      chk("piece",       8'(piece),       8'(e.p));
      chk("preview",     8'(preview),     8'(e.pv));
      chk("reject_cnt",  reject_cnt,      e.rj);
    end
  end

  initial begin
    logic [2:0] bag_seq [9];
    bag_seq = '{3'd2, 3'd2, 3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd2};

    // Reset fill with a constant accepted word.
    repeat (2) step(1'b1, 16'h0003, 1'b0);
    repeat (6) step(1'b0, 16'h0003, 1'b0);

    // Saturating rejects from empty.
    step(1'b1, 16'h0007, 1'b0);
    repeat (300) step(1'b0, 16'h0007, 1'b0);

    // Simultaneous push/pop at two entries.
    step(1'b1, 16'h0000, 1'b0);
    step(1'b0, 16'h0001, 1'b0);
    step(1'b0, 16'h0002, 1'b0);
    step(1'b0, 16'h0005, 1'b1);
    step(1'b0, 16'h0007, 1'b0);

    // Full plus a single request, then refill.
    repeat (3) step(1'b0, 16'h0003, 1'b0);
    step(1'b0, 16'h0004, 1'b1);
    step(1'b0, 16'h0004, 1'b0);
    step(1'b0, 16'h0004, 1'b0);

    // Request while empty, then reset with three queued and a request.
    step(1'b1, 16'h0007, 1'b0);
    step(1'b0, 16'h0007, 1'b1);
    step(1'b0, 16'h0007, 1'b1);
    repeat (3) step(1'b0, 16'h0006, 1'b0);
    step(1'b1, 16'h0006, 1'b1);
    step(1'b0, 16'h0007, 1'b0);

    // Bag sequence with continuous popping.
    step(1'b1, 16'h0000, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 16'(bag_seq[i]), 1'b1);

    // Randomised traffic with phases of light and heavy consumption.
    for (int i = 0; i < 3000; i++) begin
      logic rr;
      logic rq;
      rr = ($urandom_range(0, 199) == 0);
      if ((i / 250) % 2 == 0) rq = ($urandom_range(0, 3) == 0);
      else                    rq = ($urandom_range(0, 3) != 0);
      step(rr, 16'($urandom), rq);
    end

    @(negedge clk);
    rst = 1'b0;
    req = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/piece_picker.md
# piece_picker

Consumer side of the 16-bit pseudo-random stream produced by the LFSR generator. Each cycle it samples `rand_num` and converts it into a tetromino type. It buffers accepted pieces in a small preview queue and hands them to the game-control FSM over a valid/request handshake. It sits between the random generator and the spawn logic, and also drives the "next piece" preview display.

## Interface
- `QUEUE_DEPTH`, default 4: number of buffered pieces; legal range 2–8.
- `clk`, input, 1: single system clock; all logic is on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `rand_num`, input, 16: random word from the generator; sampled every cycle.
- `req`, input, 1: game FSM consumes the head piece this cycle.
- `piece_valid`, output, 1: `piece` holds a valid head entry.
- `piece`, output, 3: head piece type, 0..6.
- `preview`, output, 3: entry behind the head; reads 7 (`PIECE_NONE`) when fewer than 2 entries are held.
- `count`, output, 4: current queue occupancy.
- `reject_cnt`, output, 8: saturating count of rejected samples.

## Operation
- Candidate: `cand = rand_num[2:0] ^ rand_num[13:11]`.
- A candidate of 7 is rejected: no push, and `reject_cnt` increments, saturating at 255.
- Push: when `count < QUEUE_DEPTH` and the candidate is accepted, the candidate is written at the tail.
- When the queue is full, sampling stops. A full queue is not a reject and `reject_cnt` is unchanged.
- Pop: `req && piece_valid` removes the head.
- `req` while empty is ignored: no pop, no error.
- Push and pop in the same cycle are both performed; `count` is unchanged. If the queue was full, the pop frees a slot only for the next cycle, so no push happens in that cycle.
- `piece_valid = (count != 0)`.
- `piece` = head entry, or 0 when empty.
- `count` arithmetic is unsigned 4-bit and never exceeds `QUEUE_DEPTH`. Head and tail pointers wrap modulo `QUEUE_DEPTH`.
- Reset:
  - `count`, `reject_cnt`, pointers → 0.
  - `piece_valid` → 0, `piece` → 0, `preview` → 7.
  - Queue contents are don't-care.
- Reset asserted mid-operation discards all queued pieces in that same cycle. Any `req` in that cycle is ignored.

## Timing
- All outputs are registered or decoded from registers. There are no combinational paths from `req` or `rand_num` to outputs.
- Push latency: a candidate sampled at edge N appears in `count` after edge N. If the queue was empty, it also appears on `piece` and `piece_valid` after edge N.
- Pop latency: `req` high at edge N makes the new head visible after edge N.
- After reset release, the earliest `piece_valid` is 1 cycle later, given an accepted sample.
- Worst-case refill is unbounded in principle. The generator's sequence is deterministic, and the bench measures actual refill time.

## Configuration
- `PIECE_BAG7_EN` defined: 7-bag mode.
  - A 7-bit `used` mask is kept. A candidate whose `used` bit is already set is also rejected and counted in `reject_cnt`.
  - On push, the candidate's bit is set. When the mask reaches 7'h7F after a push, it clears to 0 on the same edge.
  - Reset clears the mask.
  - Result: every 7 consecutive pushes, aligned from reset, contain each type exactly once.
- `PIECE_BAG7_EN` undefined: no mask, no repeat rejection. Only value 7 is rejected.

## Structure
- Shared package `tetris_pkg` (also used by spawn and draw logic) holds:
  - `piece_t`: 3-bit enum with I=0, O=1, T=2, S=3, Z=4, J=5, L=6.
  - `PIECE_NONE = 3'd7`.
  - `NUM_PIECES = 7`.
- One sub-module, `piece_fifo`: parameterised circular buffer providing `push`, `pop`, `head`, `second`, `count`.
- Candidate derivation, rejection, bag mask and `reject_cnt` stay in `piece_picker`.

## Test plan
- Reset fill: release `rst` with `rand_num` held at 16'h0003 → `piece_valid`=1 and `piece`=3 one cycle later. `count` reaches 4 after 4 cycles and holds; `reject_cnt`=0.
- Reject: hold `rand_num`=16'h0007 for 300 cycles from empty → `count`=0, `piece_valid`=0, `reject_cnt` saturates at 255.
- Simultaneous push/pop: queue at 2 entries, `req`=1 with `cand`=5 accepted → `count` stays 2, old `preview` becomes `piece`, and 5 lands at the tail.
- Full plus `req`: queue at 4, `req`=1 for one cycle → `count` becomes 3; the push resumes the following cycle, giving 4.
- Empty `req` and reset mid-run: `req`=1 while empty leaves `count` at 0. Asserting `rst` with 3 entries queued and `req`=1 → `count`=0, `preview`=7 after that edge.
- `PIECE_BAG7_EN` defined: drive `cand` sequence 2,2,0,1,3,4,5,6,2 while popping continuously → pushes are 2,0,1,3,4,5,6,2; the second 2 is rejected (`reject_cnt`=1); the mask clears after 6 is pushed.
